axis_circular_acq_ctrl: RTL and testbench

Sequencer for the circular-buffer packetizer and RAM-writer chain. It arms the packetizer by pulsing its local reset, enforces a minimum pre-trigger fill, and qualifies an external or forced trigger. It holds the packetizer trigger for the post-trigger capture, detects completion on the tlast handshake, and computes the buffer read-out start address. It supports single-shot and auto-rearm operation and exposes status to the PS register bank.

---
 rtl/axis_acq_pkg.sv | 19 +
 rtl/axis_circular_acq_ctrl_trig_edge_sync.sv | 36 +++
 rtl/axis_circular_acq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_axis_circular_acq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_acq_pkg.sv
// Shared types and constants for the circular-buffer acquisition sequencer.
package axis_acq_pkg;

    localparam int unsigned ACQ_CNT_W      = 16;
    localparam int unsigned HOLDOFF_W      = 16;
    localparam int unsigned RST_CYCLES_MIN = 1;
    localparam int unsigned RST_CYCLES_MAX = 15;
    localparam int unsigned RST_CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_PRE   = 3'd2,
        ST_ARMED = 3'd3,
        ST_POST  = 3'd4,
        ST_DONE  = 3'd5
    } acq_state_e;

endpackage

// File: rtl/axis_circular_acq_ctrl_trig_edge_sync.sv
// Optional two-flop trigger synchronizer and rising-edge detector, OR'ed with the software trigger.
module trig_edge_sync #(
    parameter string TRIG_SYNC = "TRUE"
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic trig_in,
    input  logic ctrl_force,
    output logic trig_c
);

    logic trig_s;
    logic hist_q;

    generate
        if (TRIG_SYNC == "TRUE") begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge aclk) begin
                if (!aresetn) sync_q <= 2'b00;
                else          sync_q <= {sync_q[0], trig_in};
            end
            assign trig_s = sync_q[1];
        end else begin : g_bypass
            assign trig_s = trig_in;
        end
    endgenerate

    // History tracks every cycle so a level already high never looks like a fresh edge
    always_ff @(posedge aclk) begin
        if (!aresetn) hist_q <= 1'b0;
        else          hist_q <= trig_s;
    end

    assign trig_c = (trig_s & ~hist_q) | ctrl_force;

endmodule

// File: rtl/axis_circular_acq_ctrl.sv
// Arms the packetizer, enforces pre-trigger fill, qualifies the trigger and reports
// completion with the read-out start address.
module axis_circular_acq_ctrl
    import axis_acq_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH = 32,
    parameter string       TRIG_SYNC  = "TRUE",
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNTR_WIDTH-1:0] cfg_pre,
    input  logic [CNTR_WIDTH-1:0] cfg_post,
    input  logic [CNTR_WIDTH-1:0] cfg_mask,
    input  logic [HOLDOFF_W-1:0]  cfg_holdoff,
    input  logic                  ctrl_arm,
    input  logic                  ctrl_abort,
    input  logic                  ctrl_auto,
    input  logic                  ctrl_force,
    input  logic                  trig_in,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic                  mon_tlast,
    input  logic [CNTR_WIDTH-1:0] pkt_start_pos,
    output logic                  pkt_aresetn,
    output logic [CNTR_WIDTH-1:0] pkt_cfg_data,
    output logic                  pkt_trigger,
    output logic [2:0]            sts_state,
    output logic                  sts_done,
    output logic [CNTR_WIDTH-1:0] sts_trig_pos,
    output logic [CNTR_WIDTH-1:0] sts_read_start,
    output logic [ACQ_CNT_W-1:0]  sts_acq_count,
    output logic                  irq
);

    localparam int unsigned RST_LEN = (RST_CYCLES < RST_CYCLES_MIN) ? RST_CYCLES_MIN :
                                      (RST_CYCLES > RST_CYCLES_MAX) ? RST_CYCLES_MAX : RST_CYCLES;

    acq_state_e              state_q, state_d;
    logic [RST_CNT_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNTR_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
    logic [CNTR_WIDTH-1:0]   pre_eff_q, pre_eff_d;
    logic [HOLDOFF_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [HOLDOFF_W-1:0]    holdoff_q, holdoff_d;
    logic [CNTR_WIDTH-1:0]   cfg_data_d, trig_pos_d, read_start_d;
    logic [ACQ_CNT_W-1:0]    acq_cnt_d;
    logic                    done_d, irq_d, pkt_aresetn_d, pkt_trigger_d;
    logic                    arm_c, beat_c, trig_c;
    logic [CNTR_WIDTH-1:0]   pre_eff_c;

    trig_edge_sync #(.TRIG_SYNC(TRIG_SYNC)) u_trig (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .trig_in    (trig_in),
        .ctrl_force (ctrl_force),
        .trig_c     (trig_c)
    );

    assign beat_c    = mon_tvalid & mon_tready;
    assign pre_eff_c = (cfg_pre < cfg_mask) ? cfg_pre : cfg_mask;
    assign sts_state = state_q;

    // Next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        pre_cnt_d    = pre_cnt_q;
        pre_eff_d    = pre_eff_q;
        hold_cnt_d   = hold_cnt_q;
        holdoff_d    = holdoff_q;
        cfg_data_d   = pkt_cfg_data;
        done_d       = sts_done;
        trig_pos_d   = sts_trig_pos;
        read_start_d = sts_read_start;
        acq_cnt_d    = sts_acq_count;
        irq_d        = 1'b0;
        arm_c        = 1'b0;

        if (ctrl_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: arm_c = ctrl_arm;
                ST_RST: begin
                    if (rst_cnt_q == RST_CNT_W'(RST_LEN - 1))
                        state_d = (pre_eff_q == '0) ? ST_ARMED : ST_PRE;
                    else
                        rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
                ST_PRE: begin
                    if (pre_cnt_q == pre_eff_q) state_d   = ST_ARMED;
                    else if (beat_c)            pre_cnt_d = pre_cnt_q + CNTR_WIDTH'(1);
                end
                ST_ARMED: if (trig_c) state_d = ST_POST;
                ST_POST: begin
                    if (beat_c && mon_tlast) begin
                        state_d      = ST_DONE;
                        trig_pos_d   = pkt_start_pos;
                        read_start_d = (pkt_start_pos - pre_eff_q) & cfg_mask;
                        done_d       = 1'b1;
                        irq_d        = 1'b1;
                        acq_cnt_d    = sts_acq_count + ACQ_CNT_W'(1);
                        hold_cnt_d   = '0;
                    end
                end
                ST_DONE: begin
                    if (ctrl_arm)                      arm_c      = 1'b1;
                    else if (ctrl_auto) begin
                        if (hold_cnt_q == holdoff_q)   arm_c      = 1'b1;
                        else                           hold_cnt_d = hold_cnt_q + HOLDOFF_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Manual and automatic arm share the same configuration latch
            if (arm_c) begin
                state_d    = ST_RST;
                cfg_data_d = cfg_post;
                pre_eff_d  = pre_eff_c;
                holdoff_d  = cfg_holdoff;
                done_d     = 1'b0;
                rst_cnt_d  = '0;
                pre_cnt_d  = '0;
            end
        end

        pkt_aresetn_d = state_d inside {ST_PRE, ST_ARMED, ST_POST, ST_DONE};
        pkt_trigger_d = state_d inside {ST_POST, ST_DONE};
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            rst_cnt_q      <= '0;
            pre_cnt_q      <= '0;
            pre_eff_q      <= '0;
            hold_cnt_q     <= '0;
            holdoff_q      <= '0;
            pkt_cfg_data   <= '0;
            sts_done       <= 1'b0;
            sts_trig_pos   <= '0;
            sts_read_start <= '0;
            sts_acq_count  <= '0;
            irq            <= 1'b0;
            pkt_aresetn    <= 1'b0;
            pkt_trigger    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            pre_cnt_q      <= pre_cnt_d;
            pre_eff_q      <= pre_eff_d;
            hold_cnt_q     <= hold_cnt_d;
            holdoff_q      <= holdoff_d;
            pkt_cfg_data   <= cfg_data_d;
            sts_done       <= done_d;
            sts_trig_pos   <= trig_pos_d;
            sts_read_start <= read_start_d;
            sts_acq_count  <= acq_cnt_d;
            irq            <= irq_d;
            pkt_aresetn    <= pkt_aresetn_d;
            pkt_trigger    <= pkt_trigger_d;
        end
    end

endmodule

// File: tb/tb_axis_circular_acq_ctrl.sv
// Directed bench for axis_circular_acq_ctrl with a minimal packetizer model driving the taps.
module tb_axis_circular_acq_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] cfg_pre = 32'd8, cfg_post = 32'd15, cfg_mask = 32'd255;
    logic [15:0] cfg_holdoff = 16'd0;
    logic        ctrl_arm = 1'b0, ctrl_abort = 1'b0, ctrl_auto = 1'b0, ctrl_force = 1'b0;
    logic        trig_in = 1'b0;
    logic        mon_tvalid, mon_tready = 1'b1, mon_tlast;
    logic [31:0] pkt_start_pos;
    logic        pkt_aresetn, pkt_trigger;
    logic [31:0] pkt_cfg_data;
    logic [2:0]  sts_state;
    logic        sts_done;
    logic [31:0] sts_trig_pos, sts_read_start;
    logic [15:0] sts_acq_count;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Packetizer model: counts pre-trigger beats into start_pos, then passes cfg_data+1 beats
    logic        src_en = 1'b0;
    logic [31:0] m_pos = '0, m_post = '0, m_pre_raw = '0;
    logic        m_fin = 1'b0;
    int          irq_cnt = 0;
    logic        beat;

    assign mon_tvalid    = pkt_aresetn & src_en & ~m_fin;
    assign mon_tlast     = pkt_trigger & (m_post == pkt_cfg_data);
    assign beat          = mon_tvalid & mon_tready;
    assign pkt_start_pos = m_pos;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
        if (pkt_aresetn !== 1'b1) begin
            m_pos <= '0; m_post <= '0; m_pre_raw <= '0; m_fin <= 1'b0;
        end else if (beat) begin
            if (!pkt_trigger) begin
                m_pos     <= (m_pos + 32'd1) & cfg_mask;
                m_pre_raw <= m_pre_raw + 32'd1;
            end else begin
                m_post <= m_post + 32'd1;
                if (mon_tlast) m_fin <= 1'b1;
            end
        end
    end

    axis_circular_acq_ctrl dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_pre        (cfg_pre),
        .cfg_post       (cfg_post),
        .cfg_mask       (cfg_mask),
        .cfg_holdoff    (cfg_holdoff),
        .ctrl_arm       (ctrl_arm),
        .ctrl_abort     (ctrl_abort),
        .ctrl_auto      (ctrl_auto),
        .ctrl_force     (ctrl_force),
        .trig_in        (trig_in),
        .mon_tvalid     (mon_tvalid),
        .mon_tready     (mon_tready),
        .mon_tlast      (mon_tlast),
        .pkt_start_pos  (pkt_start_pos),
        .pkt_aresetn    (pkt_aresetn),
        .pkt_cfg_data   (pkt_cfg_data),
        .pkt_trigger    (pkt_trigger),
        .sts_state      (sts_state),
        .sts_done       (sts_done),
        .sts_trig_pos   (sts_trig_pos),
        .sts_read_start (sts_read_start),
        .sts_acq_count  (sts_acq_count),
        .irq            (irq)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_pre(input logic [31:0] v, input string tag);
        int n = 0;
        while (m_pre_raw != v && n < 1000) begin tick(1); n++; end
        chk(tag, m_pre_raw, v);
    endtask

    task automatic wait_post(input logic [31:0] v, input string tag);
        int n = 0;
        while (m_post != v && n < 1000) begin tick(1); n++; end
        chk(tag, m_post, v);
    endtask

    task automatic wait_state(input logic [2:0] v, input string tag);
        int n = 0;
        while (sts_state != v && n < 1000) begin tick(1); n++; end
        chk(tag, sts_state, v);
    endtask

    task automatic pulse_arm();
        ctrl_arm = 1'b1; tick(1); ctrl_arm = 1'b0;
    endtask

    task automatic pulse_trig(input int lat);
        trig_in = 1'b1; tick(lat); trig_in = 1'b0;
    endtask

    initial begin
        int n;
        tick(3);
        chk("rst_ctl", {pkt_aresetn, pkt_trigger, irq, sts_done, sts_state}, 0);
        chk("rst_sts", {sts_trig_pos, sts_read_start}, 0);
        chk("rst_cnt", {sts_acq_count, pkt_cfg_data}, 0);
        aresetn = 1'b1; src_en = 1'b1; tick(2);

        // 1: basic capture, trigger edge after 20 pre-beats; cfg change after arm ignored
        pulse_arm();
        chk("t1_rst_state", sts_state, 1);
        chk("t1_cfg_data", pkt_cfg_data, 15);
        cfg_post = 32'd3;
        wait_pre(20, "t1_pre20");
        trig_in = 1'b1;
        tick(1); chk("t1_lat1", pkt_trigger, 0);
        tick(1); chk("t1_lat2", pkt_trigger, 0);
        tick(1); chk("t1_lat3", pkt_trigger, 1);
        chk("t1_post_state", sts_state, 4);
        wait_state(5, "t1_done");
        chk("t1_irq", irq, 1);
        chk("t1_beats", m_post, 16);
        chk("t1_trig_pos", sts_trig_pos, 23);
        chk("t1_read_start", sts_read_start, 15);
        chk("t1_done_flag", sts_done, 1);
        chk("t1_acq", sts_acq_count, 1);
        chk("t1_trig_hold", pkt_trigger, 1);
        tick(1);
        chk("t1_irq_once", irq_cnt, 1);
        trig_in = 1'b0; cfg_post = 32'd15;

        // 2: edge during pre-fill is discarded, later edge triggers
        pulse_arm();
        chk("t2_done_clr", sts_done, 0);
        wait_pre(3, "t2_pre3");
        pulse_trig(1);
        wait_pre(12, "t2_pre12");
        chk("t2_no_trig", {pkt_trigger, sts_state}, 3);
        trig_in = 1'b1; tick(3);
        chk("t2_trig", pkt_trigger, 1);
        wait_state(5, "t2_done");
        chk("t2_trig_pos", sts_trig_pos, 15);
        chk("t2_read_start", sts_read_start, 7);
        chk("t2_acq", sts_acq_count, 2);
        trig_in = 1'b0;

        // 3: read-out start wraps below zero
        cfg_mask = 32'd63; cfg_pre = 32'd10;
        pulse_arm();
        wait_pre(65, "t3_pre65");
        pulse_trig(3);
        wait_state(5, "t3_done");
        chk("t3_trig_pos", sts_trig_pos, 4);
        chk("t3_read_start", sts_read_start, 58);
        chk("t3_acq", sts_acq_count, 3);

        // 4: arm ignored in POST, abort at post beat 5, then forced re-arm
        cfg_mask = 32'd255; cfg_pre = 32'd8;
        pulse_arm();
        wait_pre(20, "t4_pre20");
        trig_in = 1'b1;
        wait_state(4, "t4_post");
        trig_in = 1'b0;
        wait_post(2, "t4_post2");
        pulse_arm();
        chk("t4_arm_ignored", sts_state, 4);
        wait_post(5, "t4_post5");
        ctrl_abort = 1'b1; tick(1); ctrl_abort = 1'b0;
        chk("t4_abort", {pkt_trigger, pkt_aresetn, sts_state, sts_done}, 0);
        chk("t4_trig_pos_kept", sts_trig_pos, 4);
        pulse_arm();
        wait_pre(10, "t4_pre10");
        ctrl_force = 1'b1; tick(1); ctrl_force = 1'b0;
        chk("t4_force_lat", pkt_trigger, 1);
        wait_state(5, "t4_done");
        chk("t4_trig_pos", sts_trig_pos, 11);
        chk("t4_read_start", sts_read_start, 3);
        chk("t4_acq", sts_acq_count, 4);

        // 5: auto re-arm with holdoff 4, three captures from a fresh reset
        aresetn = 1'b0; tick(2); aresetn = 1'b1; tick(1);
        chk("t5_acq_rst", sts_acq_count, 0);
        cfg_holdoff = 16'd4; ctrl_auto = 1'b1;
        pulse_arm();
        for (int i = 0; i < 3; i++) begin
            wait_state(3, "t5_armed");
            ctrl_force = 1'b1; tick(1); ctrl_force = 1'b0;
            wait_state(5, "t5_done");
            if (i < 2) begin
                n = 0;
                while (sts_state == 3'd5 && n < 50) begin tick(1); n++; end
                chk("t5_holdoff", n, 5);
                chk("t5_rst", sts_state, 1);
            end else begin
                ctrl_auto = 1'b0;
            end
        end
        tick(10);
        chk("t5_stay_done", sts_state, 5);
        chk("t5_acq", sts_acq_count, 3);
        chk("t5_irq_total", irq_cnt, 7);

        // 6: abort beats arm; stalled beats freeze pre-fill; held-high trigger needs a new edge
        ctrl_arm = 1'b1; ctrl_abort = 1'b1; tick(1);
        ctrl_arm = 1'b0; ctrl_abort = 1'b0;
        chk("t6_abort_wins", {sts_state, sts_done}, 1);
        mon_tready = 1'b0;
        pulse_arm();
        tick(20);
        chk("t6_stall_pre", {sts_state, pkt_aresetn}, 5);
        mon_tready = 1'b1;
        wait_state(3, "t6_armed");
        ctrl_abort = 1'b1; tick(1); ctrl_abort = 1'b0;
        cfg_pre = 32'd0; trig_in = 1'b1; tick(3);
        pulse_arm();
        tick(30);
        chk("t6_hi_no_trig", {pkt_trigger, sts_state}, 3);
        trig_in = 1'b0; tick(3);
        trig_in = 1'b1; tick(3);
        chk("t6_new_edge", pkt_trigger, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
